// File: rtl/rr_mux_reg.sv
// N-channel round-robin mux feeding a registered valid/ready output stage.
// Define MUX_LOCK_EN to add packet locking (in_last / out_last).
module rr_mux_reg #(
  parameter int ANCHO     = 8,
  parameter int N_CANALES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CANALES-1:0]           in_valid,
  input  logic [N_CANALES*ANCHO-1:0]     in_data,
`ifdef MUX_LOCK_EN
  input  logic [N_CANALES-1:0]           in_last,
  output logic                           out_last,
`endif
  output logic [N_CANALES-1:0]           in_ready,
  output logic                           out_valid,
  output logic [ANCHO-1:0]               out_data,
  output logic [$clog2(N_CANALES)-1:0]   out_sel,
  input  logic                           out_ready
);
  localparam int SEL_W = $clog2(N_CANALES);

  logic [N_CANALES-1:0][ANCHO-1:0] w_lanes;
  logic [N_CANALES-1:0]            w_req;
  logic [2*N_CANALES-1:0]          w_rot2;
  logic [SEL_W-1:0]                w_off, w_gnt, w_ptr_nxt;
  logic [SEL_W:0]                  w_sum;
  logic                            w_load, w_gnt_vld, w_acc;

  logic                            r_valid;
  logic [ANCHO-1:0]                r_data;
  logic [SEL_W-1:0]                r_sel, r_ptr;

  assign w_lanes = in_data;
  assign w_load  = !r_valid || out_ready;

`ifdef MUX_LOCK_EN
  logic r_lock, r_last;

  // While locked, r_sel is the channel that owns the open packet.
  always_comb begin
    w_req = in_valid;
    if (r_lock) begin
      w_req        = '0;
      w_req[r_sel] = in_valid[r_sel];
    end
  end
`else
  assign w_req = in_valid;
`endif

  // Rotate the request vector so bit 0 is the pointer; lowest set bit wins.
  assign w_rot2 = {w_req, w_req} >> r_ptr;

  always_comb begin
    w_gnt_vld = |w_req;
    w_off     = '0;
    for (int j = N_CANALES-1; j >= 0; j--)
      if (w_rot2[j]) w_off = SEL_W'(j);
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (SEL_W+1)'(N_CANALES))
      w_sum = w_sum - (SEL_W+1)'(N_CANALES);
    w_gnt = w_sum[SEL_W-1:0];
  end

  assign w_ptr_nxt = (w_gnt == SEL_W'(N_CANALES-1)) ? '0 : w_gnt + SEL_W'(1);
  // No handshake while in reset: the edge would discard the word.
  assign w_acc     = w_load && w_gnt_vld && !rst;

  for (genvar i = 0; i < N_CANALES; i++) begin : g_rdy
    assign in_ready[i] = w_acc && (w_gnt == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
`ifdef MUX_LOCK_EN
      r_lock  <= 1'b0;
      r_last  <= 1'b0;
`endif
    end else if (w_load) begin
      r_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_data <= w_lanes[w_gnt];
        r_sel  <= w_gnt;
`ifdef MUX_LOCK_EN
        r_last <= in_last[w_gnt];
        r_lock <= !in_last[w_gnt];
        if (in_last[w_gnt]) r_ptr <= w_ptr_nxt;
`else
        r_ptr  <= w_ptr_nxt;
`endif
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
`ifdef MUX_LOCK_EN
  assign out_last  = r_last;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg: queue-free arithmetic model checked every cycle plus
// directed vectors with literal expectations (lock tests under MUX_LOCK_EN).
module tb_rr_mux_reg;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
`ifdef MUX_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  int n_vec = 0;
  int n_err = 0;

  rr_mux_reg #(.ANCHO(W), .N_CANALES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
`ifdef MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Model state: what the output stage must hold, and the next channel to try.
  bit          m_ok   = 1'b0;
  bit          m_ov   = 1'b0;
  logic [W-1:0] m_od  = '0;
  int          m_os   = 0;
  int          m_ptr  = 0;
  bit          m_lock = 1'b0;
  int          m_lch  = 0;
  bit          m_ol   = 1'b0;

  function automatic int pick(input int ptr, input logic [N-1:0] v,
                              input bit lk, input int lch);
    if (lk) return v[lch] ? lch : -1;
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int cur_g();
    return pick(m_ptr, in_valid, m_lock, m_lch);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    if (rst || (m_ov && !out_ready) || cur_g() < 0) return '0;
    return N'(1) << cur_g();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1; m_ov <= 1'b0; m_od <= '0; m_os <= 0; m_ptr <= 0;
      m_lock <= 1'b0; m_ol <= 1'b0;
    end else if (!m_ov || out_ready) begin
      m_ov <= (cur_g() >= 0);
      if (cur_g() >= 0) begin
        m_od <= in_data[cur_g()*W +: W];
        m_os <= cur_g();
`ifdef MUX_LOCK_EN
        m_ol <= in_last[cur_g()];
        if (in_last[cur_g()]) begin
          m_lock <= 1'b0;
          m_ptr  <= (cur_g() + 1) % N;
        end else begin
          m_lock <= 1'b1;
          m_lch  <= cur_g();
        end
`else
        m_ptr <= (cur_g() + 1) % N;
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model in_ready",  32'(in_ready),  32'(exp_ready()));
      chk("model out_valid", 32'(out_valid), 32'(m_ov));
      chk("model out_data",  32'(out_data),  32'(m_od));
      chk("model out_sel",   32'(out_sel),   32'(m_os));
`ifdef MUX_LOCK_EN
      chk("model out_last",  32'(out_last),  32'(m_ol));
`endif
    end
  end

  task automatic apply(input bit r, input logic [N-1:0] v, input bit ordy,
                       input logic [N-1:0] last);
    rst = r; in_valid = v; out_ready = ordy;
`ifdef MUX_LOCK_EN
    in_last = last;
`endif
    @(posedge clk); #2;
  endtask

  localparam logic [N*W-1:0] DATA_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  initial begin
    in_data = DATA_A;

    // Reset held two cycles with every channel requesting
    apply(1'b1, 4'hF, 1'b1, 4'hF);
    apply(1'b1, 4'hF, 1'b1, 4'hF);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data",  32'(out_data),  32'd0);
    chk("rst out_sel",   32'(out_sel),   32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd0);

    // Full load: strict 0,1,2,3,0 rotation at one word per cycle
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 4'hF, 1'b1, 4'hF);
      chk("rr out_valid", 32'(out_valid), 32'd1);
      chk("rr out_sel",   32'(out_sel),   32'(i % 4));
      chk("rr out_data",  32'(out_data),  32'(8'hA0 + (i % 4)));
    end

    // Backpressure: word 0 held, nothing accepted, pointer frozen at 1
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 4'hF, 1'b0, 4'hF);
      chk("stall out_sel",  32'(out_sel),  32'd0);
      chk("stall out_data", 32'(out_data), 32'hA0);
      chk("stall in_ready", 32'(in_ready), 32'd0);
    end
    apply(1'b0, 4'hF, 1'b1, 4'hF);
    chk("unstall out_sel", 32'(out_sel), 32'd1);

    // Sparse: ptr=2 serves 2, then ptr=3 wraps around to 2 again
    apply(1'b0, 4'b0100, 1'b1, 4'hF);
    chk("sparse sel a", 32'(out_sel), 32'd2);
    apply(1'b0, 4'b0100, 1'b1, 4'hF);
    chk("sparse wrap sel", 32'(out_sel), 32'd2);
    apply(1'b0, 4'b1001, 1'b1, 4'hF);
    chk("sparse sel 3", 32'(out_sel), 32'd3);
    apply(1'b0, 4'b1001, 1'b1, 4'hF);
    chk("sparse sel 0", 32'(out_sel), 32'd0);

    // Idle cycle: valid drops, data/sel hold, pointer (1) does not move
    apply(1'b0, 4'b0000, 1'b1, 4'hF);
    chk("idle out_valid", 32'(out_valid), 32'd0);
    chk("idle out_sel",   32'(out_sel),   32'd0);
    chk("idle out_data",  32'(out_data),  32'hA0);
    apply(1'b0, 4'hF, 1'b1, 4'hF);
    chk("post-idle sel", 32'(out_sel), 32'd1);

    // Mixed request/ready patterns, checked by the model only
    for (int i = 0; i < 24; i++) begin
      in_data = {4{8'(i)}} + 32'h30201000;
      apply(1'b0, 4'((i * 5 + 3) % 16), (i % 3) != 2, 4'hF);
    end
    in_data = DATA_A;

    // Reset while stalled drops the held word
    apply(1'b0, 4'hF, 1'b1, 4'hF);
    apply(1'b0, 4'hF, 1'b0, 4'hF);
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    apply(1'b1, 4'hF, 1'b0, 4'hF);
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst out_data",  32'(out_data),  32'd0);
    apply(1'b0, 4'hF, 1'b1, 4'hF);
    chk("post-rst sel",  32'(out_sel),  32'd0);
    chk("post-rst data", 32'(out_data), 32'hA0);

`ifdef MUX_LOCK_EN
    apply(1'b1, 4'h0, 1'b1, 4'hF);
    in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    apply(1'b0, 4'b0110, 1'b1, 4'b1101);
    chk("lock w1 sel", 32'(out_sel), 32'd1);
    apply(1'b0, 4'b0110, 1'b1, 4'b1101);
    chk("lock w2 sel", 32'(out_sel), 32'd1);
    apply(1'b0, 4'b0110, 1'b1, 4'hF);
    chk("lock w3 sel",  32'(out_sel),  32'd1);
    chk("lock w3 last", 32'(out_last), 32'd1);
    apply(1'b0, 4'b0110, 1'b1, 4'hF);
    chk("lock release sel", 32'(out_sel), 32'd2);
    apply(1'b0, 4'b0110, 1'b1, 4'b1101);
    chk("lock2 w1 sel", 32'(out_sel), 32'd1);
    apply(1'b0, 4'b0100, 1'b1, 4'b1101);
    chk("lock gap valid", 32'(out_valid), 32'd0);
    apply(1'b0, 4'b0110, 1'b1, 4'hF);
    chk("lock2 w2 sel", 32'(out_sel), 32'd1);
    apply(1'b0, 4'b0110, 1'b1, 4'hF);
    chk("lock2 next sel", 32'(out_sel), 32'd2);
`endif

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
